irq_timer_responder: RTL
========================

# irq_timer_responder

Memory-mapped bus responder that sits on the CPU's RAM bus (address/data/wren/q) next to the program RAM. It provides an 8-source interrupt controller with a built-in down-counting timer, and it generates the CPU's IRQ/IRQn inputs. Read data is returned with the same one-cycle latency as the synchronous RAM. The top level muxes `q` between RAM and this block using `hit`.

## Interface
Parameters:
- BASE, 16'hFF00, word address of register 0; must be 4-aligned; block decodes `address[15:2] == BASE[15:2]`.

Ports:
- clk  in  1  system clock, same as CPU.
- nreset  in  1  reset, synchronous, active-low.
- address  in  16  CPU bus word address.
- data  in  32  CPU write data.
- wren  in  1  CPU write enable.
- stall  in  1  CPU stall; a write is committed only when `stall` is 0.
- irq_in  in  8  asynchronous external interrupt sources; bit 0 is unused, because source 0 is the internal timer.
- q_io  out  32  registered read data.
- hit  out  1  registered flag: `q_io` is valid for the address sampled last cycle; top-level mux select.
- IRQ  out  1  registered: at least one pending and enabled source.
- IRQn  out  8  registered: number of the lowest-numbered pending and enabled source.

## Operation
- Register map, by offset `address[1:0]`:
  - 0 PENDING[7:0]: read returns pending bits; write is write-1-to-clear.
  - 1 MASK[7:0]: read/write; 1 = source enabled.
  - 2 RELOAD[31:0]: read/write. Writing RELOAD also loads COUNT with the written value. Writing 0 stops the timer.
  - 3 COUNT[31:0]: read returns the live count. Write loads COUNT with the data value, which restarts the period.
- Read data is zero-extended to 32 bits.
- Select and write:
  - `sel = address[15:2] == BASE[15:2]`.
  - A write commits when `sel & wren & !stall`.
  - Reads have no side effects.
- Synchronizer: `irq_in[7:1]` passes through two flops (s1, s2), then a third flop s3. A rising edge is `s2 & !s3`. Levels and falling edges are ignored.
- Pending set sources:
  - Bit k (k = 1..7) sets on a rising edge of source k.
  - Bit 0 sets on timer expiry.
- Set/clear priority: a set event in the same cycle as a W1C clear of the same bit wins; the bit stays 1.
- Timer, evaluated every cycle that is not a COUNT/RELOAD write:
  - RELOAD == 0: COUNT holds.
  - COUNT == 0 with RELOAD != 0: COUNT <= RELOAD; no expiry.
  - COUNT == 1: expiry; PENDING[0] sets and COUNT <= RELOAD.
  - Otherwise: COUNT <= COUNT - 1.
  - Period is RELOAD cycles. RELOAD = 1 expires every cycle.
- Timer is not gated by `stall`.
- Priority: IRQn is the lowest index k with `PENDING[k] & MASK[k]`. If none, IRQ = 0 and IRQn = 0.
- Clearing the serviced PENDING bit is software's job. IRQ stays high while any enabled bit remains pending.

## Timing
- Reset values:
  - Outputs: q_io = 0, hit = 0, IRQ = 0, IRQn = 0.
  - Internal: PENDING = 0, MASK = 0, RELOAD = 0, COUNT = 0, s1/s2/s3 = 0.
- Reset mid-operation discards pending interrupts and stops the timer at the next edge.
- Read latency: address sampled at edge N gives `q_io` and `hit` valid after edge N, for the whole following cycle.
  - When `sel` = 0: `hit` = 0 and `q_io` holds its previous value.
- Read-after-write: a write at edge N is visible to a read sampled at edge N+1.
- A read at the same edge as a write returns the old value.
- Interrupt path: `irq_in[k]` rising before edge N gives:
  - s1 at N, s2 at N+1, PENDING[k] at N+2;
  - IRQ/IRQn at N+3, if MASK[k] = 1.
- Timer path: PENDING[0] at the expiry edge; IRQ one edge later.
- Writes to PENDING/MASK affect IRQ one edge after commit. Example: MASK written at N gives IRQ updated at N+1.
- Stall: while `stall` = 1, writes are suppressed. Reads still update `q_io`/`hit`.

## Test plan
- Reset and readback:
  - Hold nreset = 0 for 3 cycles → all outputs 0.
  - Write MASK = 8'hA5 at FF01, then read FF01 → q_io = 32'h000000A5, hit = 1, one cycle after the address.
- Decode miss:
  - Read 16'hFF04 and 16'h00FF → hit = 0.
  - Write data 8'hFF to FF05 → MASK unchanged.
- External interrupt:
  - MASK = 8'h0C; pulse irq_in[3] high for 1 cycle at edge N → PENDING = 8'h08 at N+2; IRQ = 1, IRQn = 3 at N+3.
  - Hold irq_in[3] high → no re-trigger.
  - Write 8'h08 to FF00 → IRQ = 0 one edge later.
- Priority and collision:
  - Pend sources 2 and 5 with MASK = 8'hFF → IRQn = 2.
  - Clear bit 2 → IRQn = 5.
  - W1C bit 5 in the same cycle as a new edge on source 5 → bit 5 stays set.
- Timer:
  - RELOAD = 4 → PENDING[0] sets every 4 cycles and COUNT reads 4, 3, 2, 1.
  - Write RELOAD = 0 → no further expiries.
  - With RELOAD = 1 → expiry every cycle.
- Stall and reset:
  - Write MASK with stall = 1 → MASK unchanged; the same write after stall drops → MASK updated.
  - Assert nreset mid timer period with IRQ = 1 → IRQ = 0, COUNT = 0 after one edge.

Source files
------------

// File: rtl/irq_timer_responder.sv
// ============================================================================
// irq_timer_responder: bus-mapped 8-source interrupt controller with a
// down-counting timer on source 0.   Rev 1.0
// ============================================================================
`default_nettype none

module irq_timer_responder #(
  parameter logic [15:0] BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic        stall,
  input  logic [7:0]  irq_in,
  output logic [31:0] q_io,
  output logic        hit,
  output logic        IRQ,
  output logic [7:0]  IRQn
);

  logic [6:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] count_q, count_d;
  logic [31:0] q_io_q, q_io_d;
  logic        hit_q, hit_d;
  logic        irq_q, irq_d;
  logic [7:0]  irqn_q, irqn_d;

  logic        sel;
  logic        wr_en;
  logic [1:0]  off;
  logic [6:0]  rise;
  logic        expire;
  logic [7:0]  clr;
  logic [7:0]  active;

  // Source 0 is the internal timer, so the external bit 0 is never sampled.
  logic unused_irq0;
  assign unused_irq0 = irq_in[0];

  assign sel   = (address[15:2] == BASE[15:2]);
  assign wr_en = sel & wren & ~stall;
  assign off   = address[1:0];

  always_comb begin
    s1_d      = irq_in[7:1];
    s2_d      = s1_q;
    s3_d      = s2_q;
    rise      = s2_q & ~s3_q;

    reload_d  = reload_q;
    count_d   = count_q;
    expire    = 1'b0;
    if (wr_en && off == 2'd2) begin
      reload_d = data;
      count_d  = data;
    end else if (wr_en && off == 2'd3) begin
      count_d  = data;
    end else if (reload_q != 32'd0) begin
      if (count_q == 32'd0) begin
        count_d = reload_q;
      end else if (count_q == 32'd1) begin
        expire  = 1'b1;
        count_d = reload_q;
      end else begin
        count_d = count_q - 32'd1;
      end
    end

    // Set events are OR-ed in after the clear so a colliding set wins.
    clr       = (wr_en && off == 2'd0) ? data[7:0] : 8'd0;
    pending_d = (pending_q & ~clr) | {rise, expire};
    mask_d    = (wr_en && off == 2'd1) ? data[7:0] : mask_q;

    active    = pending_q & mask_q;
    irq_d     = |active;
    irqn_d    = 8'd0;
    for (int k = 7; k >= 0; k--) begin
      if (active[k]) irqn_d = 8'(k);
    end

    hit_d     = sel;
    q_io_d    = q_io_q;
    if (sel) begin
      case (off)
        2'd0:    q_io_d = {24'd0, pending_q};
        2'd1:    q_io_d = {24'd0, mask_q};
        2'd2:    q_io_d = reload_q;
        default: q_io_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s1_q      <= 7'd0;
      s2_q      <= 7'd0;
      s3_q      <= 7'd0;
      pending_q <= 8'd0;
      mask_q    <= 8'd0;
      reload_q  <= 32'd0;
      count_q   <= 32'd0;
      q_io_q    <= 32'd0;
      hit_q     <= 1'b0;
      irq_q     <= 1'b0;
      irqn_q    <= 8'd0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      q_io_q    <= q_io_d;
      hit_q     <= hit_d;
      irq_q     <= irq_d;
      irqn_q    <= irqn_d;
    end
  end

  assign q_io = q_io_q;
  assign hit  = hit_q;
  assign IRQ  = irq_q;
  assign IRQn = irqn_q;

endmodule

`default_nettype wire
